// File: rtl/ysyx_22041211_core_ctrl_if.sv
// Fetch and load/store handshake bundle between the core controller and its memories.
// The master side is the controller; the slave side is the memory/bench.
interface ysyx_22041211_core_ctrl_if;
   logic        ifu_req_valid_o;
   logic        ifu_req_ready_i;
   logic        ifu_rsp_valid_i;
   logic [31:0] inst_i;
   logic        lsu_req_valid_o;
   logic        lsu_req_ready_i;
   logic        lsu_rsp_valid_i;

   modport master (
      output ifu_req_valid_o,
      input  ifu_req_ready_i,
      input  ifu_rsp_valid_i,
      input  inst_i,
      output lsu_req_valid_o,
      input  lsu_req_ready_i,
      input  lsu_rsp_valid_i
   );

   modport slave (
      input  ifu_req_valid_o,
      output ifu_req_ready_i,
      output ifu_rsp_valid_i,
      output inst_i,
      input  lsu_req_valid_o,
      output lsu_req_ready_i,
      output lsu_rsp_valid_i
   );
endinterface

// File: rtl/ysyx_22041211_core_ctrl.sv
// Multi-cycle core controller: fetch, execute, optional memory access, write-back.
// Sequences the fetch/LSU handshakes, owns the PC and the retired-instruction counter.
module ysyx_22041211_core_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic                              clk,
   input  logic                              rst,
   ysyx_22041211_core_ctrl_if.master         bus,
   output logic [31:0]                       inst_o,
   output logic [31:0]                       pc_o,
   input  logic                              dec_wd_i,
   input  logic                              dec_load_i,
   input  logic                              dec_store_i,
   input  logic                              dec_illegal_i,
   input  logic [2:0]                        dec_branch_type_i,
   input  logic                              branch_taken_i,
   input  logic [31:0]                       branch_target_i,
   output logic                              reg_we_o,
   output logic                              retire_o,
   output logic [31:0]                       instret_o,
   output logic                              halt_o,
   output logic [2:0]                        state_o
);

   typedef enum logic [2:0] {
      IF_REQ   = 3'd0,
      IF_WAIT  = 3'd1,
      EX       = 3'd2,
      MEM_REQ  = 3'd3,
      MEM_WAIT = 3'd4,
      WB       = 3'd5,
      HALT     = 3'd6
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] instret_q, instret_d;
   logic        we_q, we_d;
   logic [31:0] nextPc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IF_REQ;
         pc_q      <= RESET_PC;
         inst_q    <= 32'd0;
         instret_q <= 32'd0;
         we_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         instret_q <= instret_d;
         we_q      <= we_d;
      end
   end

   // The write enable is sampled in EX so that reg_we_o in WB depends on state only.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      instret_d = instret_q;
      we_d      = we_q;
      nextPc    = ((dec_branch_type_i != 3'd0) && branch_taken_i) ? branch_target_i
                                                                 : pc_q + 32'd4;
      case (state_q)
         IF_REQ:   if (bus.ifu_req_ready_i) state_d = IF_WAIT;
         IF_WAIT: begin
            if (bus.ifu_rsp_valid_i) begin
               inst_d  = bus.inst_i;
               state_d = EX;
            end
         end
         EX: begin
            we_d = dec_wd_i & ~dec_store_i;
            if (dec_illegal_i)                  state_d = HALT;
            else if (dec_load_i || dec_store_i) state_d = MEM_REQ;
            else                                state_d = WB;
         end
         MEM_REQ:  if (bus.lsu_req_ready_i) state_d = MEM_WAIT;
         MEM_WAIT: if (bus.lsu_rsp_valid_i) state_d = WB;
         WB: begin
            instret_d = instret_q + 32'd1;
            // A misaligned target still retires but stops the core with the old PC.
            if (nextPc[1:0] != 2'b00) begin
               state_d = HALT;
            end else begin
               pc_d    = nextPc;
               state_d = IF_REQ;
            end
         end
         HALT:     state_d = HALT;
         default:  state_d = IF_REQ;
      endcase
   end

   assign bus.ifu_req_valid_o = (state_q == IF_REQ);
   assign bus.lsu_req_valid_o = (state_q == MEM_REQ);
   assign reg_we_o            = (state_q == WB) & we_q;
   assign retire_o            = (state_q == WB);
   assign halt_o              = (state_q == HALT);
   assign state_o             = state_q;
   assign pc_o                = pc_q;
   assign inst_o              = inst_q;
   assign instret_o           = instret_q;

endmodule
